// File: rtl/accumulator_n.sv
// Two-stage add/subtract accumulator with carry/overflow flags, sticky flags and a saturating sample count.
// Define ACC_SAT_EN to clamp the sum on signed overflow instead of wrapping modulo 2^WIDTH.
module accumulator_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sub,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] sum,
    output logic             c,
    output logic             v,
    output logic             c_sticky,
    output logic             v_sticky,
    output logic [CNT_W-1:0] count,
    output logic             out_valid
);

    logic             sub_q;
    logic             vld1;

    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] nxt_sum;
    logic             op_c;
    logic             op_v;

    // Stage 1: capture the operand. Clear does not block capture, so an operand
    // presented alongside clear still accumulates on the following edge.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_reg <= '0;
            sub_q <= 1'b0;
            vld1  <= 1'b0;
        end else if (en) begin
            a_reg <= a;
            sub_q <= sub;
            vld1  <= 1'b1;
        end else begin
            vld1  <= 1'b0;
        end
    end

    // Subtraction is sum + ~a_reg + 1, so c=1 means no borrow.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        operand  = sub_q ? ~a_reg : a_reg;
        add_full = {1'b0, sum} + {1'b0, operand} + {{WIDTH{1'b0}}, sub_q};
        op_c     = add_full[WIDTH];
        op_v     = (sum[WIDTH-1] == operand[WIDTH-1]) &&
                   (add_full[WIDTH-1] != sum[WIDTH-1]);
        nxt_sum  = add_full[WIDTH-1:0];
`ifdef ACC_SAT_EN
        // On overflow the true result carries the sign the two operands share.
        if (op_v) begin
            nxt_sum = sum[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Stage 2: accumulate, update flags and the saturating sample count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum       <= '0;
            c         <= 1'b0;
            v         <= 1'b0;
            c_sticky  <= 1'b0;
            v_sticky  <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            sum       <= '0;
            c         <= 1'b0;
            v         <= 1'b0;
            c_sticky  <= 1'b0;
            v_sticky  <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
        end else if (vld1) begin
            sum       <= nxt_sum;
            c         <= op_c;
            v         <= op_v;
            c_sticky  <= c_sticky | op_c;
            v_sticky  <= v_sticky | op_v;
            if (count != {CNT_W{1'b1}}) begin
                count <= count + CNT_W'(1);
            end
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accumulator_n.sv
// Directed bench for accumulator_n: an 8/8 instance for function and flags, an 8/2 instance
// for count saturation under back-to-back input. Expected sums follow ACC_SAT_EN when defined.
module tb_accumulator_n;

    logic       clk = 1'b0;
    logic       reset_n, en, sub, clear;
    logic [7:0] a;

    logic [7:0] a_reg, sum;
    logic       c, v, c_sticky, v_sticky, out_valid;
    logic [7:0] count;

    logic [7:0] a_reg2, sum2;
    logic       c2, v2, c_sticky2, v_sticky2, out_valid2;
    logic [1:0] count2;

    int n_cmp = 0;
    int n_err = 0;

    // {a_reg, sum, c, v, c_sticky, v_sticky, count, out_valid}
    wire [28:0] obs  = {a_reg, sum, c, v, c_sticky, v_sticky, count, out_valid};
    // {sum, c, v, count, out_valid} of the narrow-count instance
    wire [12:0] obs2 = {sum2, c2, v2, count2, out_valid2};

`ifdef ACC_SAT_EN
    localparam logic [7:0] OVF_SUM = 8'h7F;
`else
    localparam logic [7:0] OVF_SUM = 8'h80;
`endif

    accumulator_n #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sub(sub), .clear(clear), .a(a),
        .a_reg(a_reg), .sum(sum), .c(c), .v(v), .c_sticky(c_sticky),
        .v_sticky(v_sticky), .count(count), .out_valid(out_valid)
    );

    accumulator_n #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .sub(sub), .clear(clear), .a(a),
        .a_reg(a_reg2), .sum(sum2), .c(c2), .v(v2), .c_sticky(c_sticky2),
        .v_sticky(v_sticky2), .count(count2), .out_valid(out_valid2)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic s, input logic cl, input logic [7:0] val);
        en = e; sub = s; clear = cl; a = val;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h55);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs !== 29'h0) begin
                n_err++;
                $display("FAIL reset_dut edge%0d: got %h want %h", i, obs, 29'h0);
            end
            n_cmp++;
            if (obs2 !== 13'h0) begin
                n_err++;
                $display("FAIL reset_dut2 edge%0d: got %h want %h", i, obs2, 13'h0);
            end
        end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        n_cmp++;
        if (obs !== 29'h0) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs, 29'h0);
        end
    endtask

    task automatic test_add_overflow();
        logic [28:0] exp;
        drive(1'b1, 1'b0, 1'b0, 8'h7F); tick();
        drive(1'b1, 1'b0, 1'b0, 8'h01); tick();
        exp = {8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL add_7f: got %h want %h", obs, exp);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        exp = {8'h01, OVF_SUM, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL add_overflow: got %h want %h", obs, exp);
        end
        tick();
        exp = {8'h01, OVF_SUM, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL add_hold: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_carry();
        logic [28:0] exp;
        drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
        exp = {8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL carry_clear: got %h want %h", obs, exp);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h01); tick();
        drive(1'b1, 1'b0, 1'b0, 8'hFF); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        exp = {8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL carry_out: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_subtract();
        logic [28:0] exp;
        drive(1'b1, 1'b1, 1'b0, 8'h01); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        exp = {8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL sub_borrow: got %h want %h", obs, exp);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h80); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        exp = {8'h80, OVF_SUM, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL sub_overflow: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_clear_drop();
        logic [28:0] exp;
        drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
        drive(1'b1, 1'b0, 1'b0, 8'h10); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        exp = {8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL clear_setup: got %h want %h", obs, exp);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h05); tick();
        drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
        exp = {8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL clear_inflight: got %h want %h", obs, exp);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL clear_dropped: got %h want %h", obs, exp);
        end
        // Operand captured during clear survives and accumulates afterwards.
        drive(1'b1, 1'b0, 1'b1, 8'h03); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        exp = {8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL clear_capture: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp2;
        logic [28:0] exp;
        logic [7:0]  es;
        logic [1:0]  ec;
        drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
        for (int k = 1; k <= 7; k++) begin
            if (k <= 5) drive(1'b1, 1'b0, 1'b0, 8'h01);
            else        drive(1'b0, 1'b0, 1'b0, 8'h00);
            tick();
            es   = (k == 1) ? 8'd0 : (k >= 6) ? 8'd5 : 8'(k - 1);
            ec   = (k == 1) ? 2'd0 : (k >= 4) ? 2'd3 : 2'(k - 1);
            exp2 = {es, 1'b0, 1'b0, ec, (k >= 2 && k <= 6)};
            n_cmp++;
            if (obs2 !== exp2) begin
                n_err++;
                $display("FAIL b2b_cnt2 cycle%0d: got %h want %h", k, obs2, exp2);
            end
        end
        exp = {8'h01, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_cnt8: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_carry();
        test_subtract();
        test_clear_drop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
